gsensor_spi_responder: RTL and testbench

//  Behavioural-synthesisable responder for the 3-wire SPI link of the board's ADXL345-class
//  g-sensor (mode 3, shared bidirectional SDAT, CS_N, INT). It answers the Nios accelerometer SPI

---
 rtl/gsensor_spi_responder_pkg.sv | 28 ++
 rtl/spi_pin_sync.sv | 42 ++++
 rtl/gsensor_spi_responder.sv | 218 +++++++++++++++++++++
 tb/tb_gsensor_spi_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_spi_responder_pkg.sv
// Shared definitions for the g-sensor SPI responder: register addresses, FSM states,
// and helpers that classify register addresses.
package gsensor_resp_pkg;

  localparam logic [5:0] A_DEVID      = 6'h00;
  localparam logic [5:0] A_BW_RATE    = 6'h2C;
  localparam logic [5:0] A_INT_ENABLE = 6'h2E;
  localparam logic [5:0] A_INT_SOURCE = 6'h30;
  localparam logic [5:0] A_DATAX0     = 6'h32;
  localparam logic [5:0] A_DATAX1     = 6'h33;
  localparam logic [5:0] A_DATAY0     = 6'h34;
  localparam logic [5:0] A_DATAY1     = 6'h35;
  localparam logic [5:0] A_DATAZ0     = 6'h36;
  localparam logic [5:0] A_DATAZ1     = 6'h37;

  localparam logic [7:0] BW_RATE_RST  = 8'h0A;

  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;

  function automatic logic is_writable(input logic [5:0] a);
    return ((a >= 6'h1D) && (a <= 6'h2F) && (a != 6'h2B)) || (a == 6'h31) || (a == 6'h38);
  endfunction

  function automatic logic is_data(input logic [5:0] a);
    return (a >= A_DATAX0) && (a <= A_DATAZ1);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the SPI pins into the clk domain and produces single-cycle edge pulses.
// A pin edge becomes a pulse visible to the clk domain SYNC_STAGES+1 clocks later.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_sdat,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_sdat
);

  logic [SYNC_STAGES:0]   r_sclk_sh;
  logic [SYNC_STAGES:0]   r_cs_sh;
  logic [SYNC_STAGES-1:0] r_sdat_sh;

  // cs_n starts as "selected" so that a responder reset while the master holds CS_N low
  // sees no edge until the master actually deselects.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sh <= {(SYNC_STAGES+1){1'b1}};
      r_cs_sh   <= {(SYNC_STAGES+1){1'b0}};
      r_sdat_sh <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sclk_sh <= {r_sclk_sh[SYNC_STAGES-1:0], i_sclk};
      r_cs_sh   <= {r_cs_sh[SYNC_STAGES-1:0], i_cs_n};
      r_sdat_sh <= {r_sdat_sh[SYNC_STAGES-2:0], i_sdat};
    end
  end

  assign o_sclk_rise =  r_sclk_sh[SYNC_STAGES-1] & ~r_sclk_sh[SYNC_STAGES];
  assign o_sclk_fall = ~r_sclk_sh[SYNC_STAGES-1] &  r_sclk_sh[SYNC_STAGES];
  assign o_cs_rise   =  r_cs_sh[SYNC_STAGES-1]   & ~r_cs_sh[SYNC_STAGES];
  assign o_cs_fall   = ~r_cs_sh[SYNC_STAGES-1]   &  r_cs_sh[SYNC_STAGES];
  assign o_sdat      =  r_sdat_sh[SYNC_STAGES-1];

endmodule

// File: rtl/gsensor_spi_responder.sv
// 3-wire SPI (mode 3) responder that mimics an ADXL345-class accelerometer register map.
// Define GSENSOR_SNAPSHOT_EN to read DATA bursts from a shadow captured at command decode.
module gsensor_spi_responder
  import gsensor_resp_pkg::*;
#(
  parameter logic [7:0] DEVID_VAL   = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_sdat_in,
  output logic               spi_sdat_out,
  output logic               spi_sdat_oe,
  output logic               g_sensor_int,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_x,
  input  logic signed [15:0] sample_y,
  input  logic signed [15:0] sample_z
);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_sdat;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk       (clk_clk),
    .i_rst_n     (reset_reset_n),
    .i_sclk      (spi_sclk),
    .i_cs_n      (spi_cs_n),
    .i_sdat      (spi_sdat_in),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_cs_rise   (w_cs_rise),
    .o_cs_fall   (w_cs_fall),
    .o_sdat      (w_sdat)
  );

  state_t     r_state, w_state_nxt;
  logic       r_armed;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [5:0] r_addr;
  logic       r_mb;
  logic       r_oe;
  logic       r_out;
  logic [7:0] r_regs [0:63];
  logic       r_dready;
  logic       r_ovr;
  logic       r_int;

  logic [7:0] w_cmd;
  logic [7:0] w_wbyte;
  logic [7:0] w_rd_byte;
  logic [5:0] w_addr_nxt;
  logic       w_cmd_done;
  logic       w_rd_load;
  logic       w_wr_commit;
  logic       w_data_load;

  assign w_cmd       = {r_shift[6:0], w_sdat};
  assign w_wbyte     = {r_shift[6:0], w_sdat};
  assign w_addr_nxt  = r_mb ? (r_addr + 6'd1) : r_addr;
  assign w_cmd_done  = (r_state == CMD)   && w_sclk_rise && (r_bitcnt == 3'd7) && !w_cs_rise;
  assign w_rd_load   = (r_state == RDATA) && w_sclk_fall && (r_bitcnt == 3'd0) && !w_cs_rise;
  assign w_wr_commit = (r_state == WDATA) && w_sclk_rise && (r_bitcnt == 3'd7) && !w_cs_rise;
  assign w_data_load = w_rd_load && is_data(r_addr);

`ifdef GSENSOR_SNAPSHOT_EN
  logic [7:0] r_snap [0:5];
  logic       r_snap_act;
  logic [2:0] w_snap_idx;

  assign w_snap_idx = 3'(r_addr - A_DATAX0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_snap_act <= 1'b0;
      for (int i = 0; i < 6; i++) r_snap[i] <= 8'h00;
    end else if (w_cs_rise) begin
      r_snap_act <= 1'b0;
    end else if (w_cmd_done) begin
      r_snap_act <= w_cmd[7] && is_data(w_cmd[5:0]);
      if (w_cmd[7] && is_data(w_cmd[5:0])) begin
        for (int i = 0; i < 6; i++) r_snap[i] <= r_regs[int'(A_DATAX0) + i];
      end
    end
  end
`endif

  always_comb begin
    w_rd_byte = 8'h00;
    if (r_addr == A_DEVID) begin
      w_rd_byte = DEVID_VAL;
    end else if (r_addr == A_INT_SOURCE) begin
      w_rd_byte = {r_dready, 6'b000000, r_ovr};
    end else if (is_data(r_addr)) begin
`ifdef GSENSOR_SNAPSHOT_EN
      w_rd_byte = r_snap_act ? r_snap[w_snap_idx] : r_regs[r_addr];
`else
      w_rd_byte = r_regs[r_addr];
`endif
    end else if (is_writable(r_addr)) begin
      w_rd_byte = r_regs[r_addr];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  // A CS_N fall is only honoured once a deselect has been seen since reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall && r_armed) w_state_nxt = CMD;
      CMD:     if (w_cmd_done) w_state_nxt = w_cmd[7] ? RDATA : WDATA;
      RDATA:   w_state_nxt = RDATA;
      WDATA:   w_state_nxt = WDATA;
      default: w_state_nxt = IDLE;
    endcase
    if (w_cs_rise) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_armed  <= 1'b0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_addr   <= 6'd0;
      r_mb     <= 1'b0;
      r_oe     <= 1'b0;
      r_out    <= 1'b0;
    end else begin
      if (w_cs_rise) r_armed <= 1'b1;
      if (w_cs_rise) begin
        r_oe     <= 1'b0;
        r_bitcnt <= 3'd0;
      end else begin
        case (r_state)
          IDLE: r_bitcnt <= 3'd0;
          CMD: begin
            if (w_sclk_rise) begin
              r_shift  <= w_cmd;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_cmd_done) begin
                r_addr <= w_cmd[5:0];
                r_mb   <= w_cmd[6];
              end
            end
          end
          // Each byte is fetched on its first SCLK fall; the address steps at that fetch.
          RDATA: begin
            if (w_sclk_fall) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd0) begin
                r_out   <= w_rd_byte[7];
                r_shift <= {w_rd_byte[6:0], 1'b0};
                r_oe    <= 1'b1;
                r_addr  <= w_addr_nxt;
              end else begin
                r_out   <= r_shift[7];
                r_shift <= {r_shift[6:0], 1'b0};
              end
            end
          end
          WDATA: begin
            if (w_sclk_rise) begin
              r_shift  <= w_wbyte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_addr <= w_addr_nxt;
            end
          end
          default: r_bitcnt <= 3'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 64; i++) r_regs[i] <= (i == int'(A_BW_RATE)) ? BW_RATE_RST : 8'h00;
    end else begin
      if (w_wr_commit && is_writable(r_addr)) r_regs[r_addr] <= w_wbyte;
      if (sample_valid) begin
        r_regs[A_DATAX0] <= sample_x[7:0];
        r_regs[A_DATAX1] <= sample_x[15:8];
        r_regs[A_DATAY0] <= sample_y[7:0];
        r_regs[A_DATAY1] <= sample_y[15:8];
        r_regs[A_DATAZ0] <= sample_z[7:0];
        r_regs[A_DATAZ1] <= sample_z[15:8];
      end
    end
  end

  // A new sample beats a same-cycle DATA read: the status bits stay or become set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_dready <= 1'b0;
      r_ovr    <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      if (sample_valid) begin
        r_dready <= 1'b1;
        r_ovr    <= r_ovr | r_dready;
      end else if (w_data_load) begin
        r_dready <= 1'b0;
        r_ovr    <= 1'b0;
      end
      r_int <= |({r_dready, 6'b000000, r_ovr} & r_regs[A_INT_ENABLE]);
    end
  end

  assign spi_sdat_out = r_out;
  assign spi_sdat_oe  = r_oe;
  assign g_sensor_int = r_int;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for gsensor_spi_responder: SPI master model at SCLK = clk/8, register
// vector table plus hand-written sequences for interrupts, bursts, partial writes and reset.
module tb_gsensor_spi_responder;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sclk = 1'b1;
  logic               cs_n = 1'b1;
  logic               sdat_in = 1'b0;
  logic               sdat_out, sdat_oe, g_int;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sx = '0, sy = '0, sz = '0;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] rbuf [0:7];
  logic       rd_oe_all, rd_oe_any;

  always #5 clk = ~clk;

  gsensor_spi_responder dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .spi_sclk      (sclk),
    .spi_cs_n      (cs_n),
    .spi_sdat_in   (sdat_in),
    .spi_sdat_out  (sdat_out),
    .spi_sdat_oe   (sdat_oe),
    .g_sensor_int  (g_int),
    .sample_valid  (sample_valid),
    .sample_x      (sx),
    .sample_y      (sy),
    .sample_z      (sz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_high();
    @(negedge clk);
    sclk = 1'b1;
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sclk = 1'b0;
      sdat_in = b[i];
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic oe_all, output logic oe_any);
    b = 8'h00;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      wait_clks(4);
      b[i] = sdat_out;
      oe_all = oe_all & sdat_oe;
      oe_any = oe_any | sdat_oe;
      sclk = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic spi_read(input logic [7:0] cmd, input int n);
    logic [7:0] b;
    logic       a, o;
    cs_low();
    send_bits(cmd, 8);
    rd_oe_all = 1'b1;
    rd_oe_any = 1'b0;
    for (int k = 0; k < n; k++) begin
      recv_byte(b, a, o);
      rbuf[k] = b;
      rd_oe_all = rd_oe_all & a;
      rd_oe_any = rd_oe_any | o;
    end
    cs_high();
  endtask

  task automatic spi_write(input logic [7:0] cmd, input int n, input logic [7:0] b0, input logic [7:0] b1);
    cs_low();
    send_bits(cmd, 8);
    if (n > 0) send_bits(b0, 8);
    if (n > 1) send_bits(b1, 8);
    cs_high();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sx = x; sy = y; sz = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_clks(3);
  endtask

  typedef struct {
    string      name;
    logic       do_wr;
    logic [7:0] wcmd;
    logic [7:0] wdata;
    logic [7:0] rcmd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    logic [7:0] b;
    logic       a, o;

    vecs[0]  = '{"devid",         1'b0, 8'h00, 8'h00, 8'h80, 8'hE5};
    vecs[1]  = '{"bw_rate_rst",   1'b0, 8'h00, 8'h00, 8'hAC, 8'h0A};
    vecs[2]  = '{"int_en_rst",    1'b0, 8'h00, 8'h00, 8'hAE, 8'h00};
    vecs[3]  = '{"wr_2d",         1'b1, 8'h2D, 8'h08, 8'hAD, 8'h08};
    vecs[4]  = '{"wr_devid_ign",  1'b1, 8'h00, 8'h12, 8'h80, 8'hE5};
    vecs[5]  = '{"wr_2b_ign",     1'b1, 8'h2B, 8'h55, 8'hAB, 8'h00};
    vecs[6]  = '{"wr_31",         1'b1, 8'h31, 8'h0B, 8'hB1, 8'h0B};
    vecs[7]  = '{"wr_38",         1'b1, 8'h38, 8'h9C, 8'hB8, 8'h9C};
    vecs[8]  = '{"wr_10_unlisted",1'b1, 8'h10, 8'h77, 8'h90, 8'h00};
    vecs[9]  = '{"wr_1d",         1'b1, 8'h1D, 8'hA5, 8'h9D, 8'hA5};
    vecs[10] = '{"wr_32_ro",      1'b1, 8'h32, 8'h11, 8'hB2, 8'h00};

    wait_clks(3);
    check("rst_oe", {31'd0, sdat_oe}, 32'd0);
    check("rst_out", {31'd0, sdat_out}, 32'd0);
    check("rst_int", {31'd0, g_int}, 32'd0);
    rst_n = 1'b1;
    wait_clks(8);

    // Read DEVID with explicit output-enable timing
    cs_low();
    send_bits(8'h80, 8);
    check("oe_after_cmd", {31'd0, sdat_oe}, 32'd0);
    recv_byte(b, a, o);
    check("devid_byte", {24'd0, b}, 32'hE5);
    check("oe_during_read", {31'd0, a}, 32'd1);
    cs_high();
    check("oe_after_cs_rise", {31'd0, sdat_oe}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) spi_write(vecs[i].wcmd, 1, vecs[i].wdata, 8'h00);
      spi_read(vecs[i].rcmd, 1);
      check(vecs[i].name, {24'd0, rbuf[0]}, {24'd0, vecs[i].exp});
    end

    // Data-ready interrupt and 6-byte burst
    spi_write(8'h2E, 1, 8'h80, 8'h00);
    pulse_sample(16'h0123, 16'hFF80, 16'h0100);
    check("int_set", {31'd0, g_int}, 32'd1);
    spi_read(8'hF2, 6);
    check("burst0", {24'd0, rbuf[0]}, 32'h23);
    check("burst1", {24'd0, rbuf[1]}, 32'h01);
    check("burst2", {24'd0, rbuf[2]}, 32'h80);
    check("burst3", {24'd0, rbuf[3]}, 32'hFF);
    check("burst4", {24'd0, rbuf[4]}, 32'h00);
    check("burst5", {24'd0, rbuf[5]}, 32'h01);
    check("int_cleared", {31'd0, g_int}, 32'd0);

    // Overrun
    pulse_sample(16'h1111, 16'h0000, 16'h0000);
    pulse_sample(16'h2222, 16'h0000, 16'h0000);
    spi_read(8'hB0, 1);
    check("int_source_ovr", {24'd0, rbuf[0]}, 32'h81);
    spi_read(8'hB2, 1);
    check("datax0_latest", {24'd0, rbuf[0]}, 32'h22);
    spi_read(8'hB0, 1);
    check("int_source_clr", {24'd0, rbuf[0]}, 32'h00);

    // Address wrap and MB=0 repeat, plus multi-byte write
    spi_read(8'hFF, 2);
    check("wrap_3f", {24'd0, rbuf[0]}, 32'h00);
    check("wrap_00", {24'd0, rbuf[1]}, 32'hE5);
    spi_read(8'hBF, 2);
    check("nomb_0", {24'd0, rbuf[0]}, 32'h00);
    check("nomb_1", {24'd0, rbuf[1]}, 32'h00);
    spi_write(8'h5E, 2, 8'hAA, 8'hBB);
    spi_read(8'hDE, 2);
    check("mbwr_1e", {24'd0, rbuf[0]}, 32'hAA);
    check("mbwr_1f", {24'd0, rbuf[1]}, 32'hBB);

    // Partial write byte discarded
    cs_low();
    send_bits(8'h2D, 8);
    send_bits(8'hFF, 4);
    cs_high();
    spi_read(8'hAD, 1);
    check("partial_wr", {24'd0, rbuf[0]}, 32'h08);

    // Async reset mid-read, released while CS_N still low
    cs_low();
    send_bits(8'h80, 8);
    sclk = 1'b0;
    wait_clks(4);
    check("oe_before_rst", {31'd0, sdat_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("oe_async_rst", {31'd0, sdat_oe}, 32'd0);
    @(negedge clk);
    sclk = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(6);
    send_bits(8'h80, 8);
    recv_byte(b, a, o);
    check("idle_until_cs_rise", {31'd0, o}, 32'd0);
    cs_high();
    spi_read(8'h80, 1);
    check("devid_after_rst", {24'd0, rbuf[0]}, 32'hE5);
    spi_read(8'hAD, 1);
    check("reg_after_rst", {24'd0, rbuf[0]}, 32'h00);
    check("oe_read_after_rst", {31'd0, rd_oe_all}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
